vec_seq_ctrl: RTL and testbench

VEC_SEQ_CTRL -- requirements
Module: vec_seq_ctrl

---
 rtl/vec_seq_pkg.sv | 23 ++
 rtl/vec_elem_alu.sv | 22 ++
 rtl/vec_seq_ctrl.sv | 101 ++++++++++
 tb/tb_vec_seq_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/vec_seq_pkg.sv
// vec_seq_pkg: op codes, FSM states and default sizes for the vector sequencer.
// VSEQ_REDUCE_EN selects VRSUM (sum reduction) for op 11 instead of VORRS.
package vec_seq_pkg;
  localparam int VSEQ_DW    = 32;
  localparam int VSEQ_VLEN  = 5;
  localparam int VSEQ_NVREG = 4;
  typedef enum logic [1:0] {
    OP_ADDS = 2'b00,
    OP_SUBS = 2'b01,
    OP_ANDS = 2'b10,
`ifdef VSEQ_REDUCE_EN
    OP_RSUM = 2'b11
`else
    OP_ORRS = 2'b11
`endif
  } op_e;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_DONE  = 2'b11
  } state_e;
endpackage

// File: rtl/vec_elem_alu.sv
// vec_elem_alu: combinational element-by-scalar operation, modulo 2^DW.
// With VSEQ_REDUCE_EN, op 11 adds (b carries the running sum); otherwise it ORs.
module vec_elem_alu
  import vec_seq_pkg::*;
#(
  parameter int DW = VSEQ_DW
) (
  input  op_e           op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] y
);
  always_comb
    y = (op == OP_ADDS) ? a + b :
        (op == OP_SUBS) ? a - b :
        (op == OP_ANDS) ? a & b :
`ifdef VSEQ_REDUCE_EN
        a + b;
`else
        a | b;
`endif
endmodule

// File: rtl/vec_seq_ctrl.sv
// vec_seq_ctrl: reads one vector register element by element, applies op with a scalar,
// writes the result back in a single cycle. VSEQ_REDUCE_EN adds the VRSUM reduction.
module vec_seq_ctrl
  import vec_seq_pkg::*;
#(
  parameter int DW    = VSEQ_DW,
  parameter int VLEN  = VSEQ_VLEN,
  parameter int NVREG = VSEQ_NVREG
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [1:0]                 op,
  input  logic [$clog2(NVREG)-1:0]   vs,
  input  logic [$clog2(NVREG)-1:0]   vd,
  input  logic [DW-1:0]              scalar,
  input  logic [VLEN*DW-1:0]         rf_rdata,
  output logic [$clog2(NVREG)-1:0]   rf_va,
  output logic                       rf_we,
  output logic [$clog2(NVREG)-1:0]   rf_vd,
  output logic [VLEN*DW-1:0]         rf_wdata,
  output logic                       busy,
  output logic                       done,
  output logic [DW-1:0]              red_result
);
  localparam int IW = (VLEN > 1) ? $clog2(VLEN) : 1;
  localparam int RW = $clog2(NVREG);
  state_e             state_q, state_d;
  op_e                op_q;
  logic [RW-1:0]      vs_q, vd_q;
  logic [DW-1:0]      scalar_q, elem, alu_b, alu_y;
  logic [IW-1:0]      idx_q;
  logic [VLEN*DW-1:0] buf_q, buf_d;
  logic               accept, rd, last, rsum;
  assign accept = (state_q == ST_IDLE) && start;
  assign rd     = (state_q == ST_READ);
  assign last   = (idx_q == IW'(VLEN - 1));
  assign elem   = rf_rdata[idx_q*DW +: DW];
`ifdef VSEQ_REDUCE_EN
  logic [DW-1:0] red_q;
  assign rsum       = (op_q == OP_RSUM);
  assign alu_b      = rsum ? red_q : scalar_q;
  assign red_result = red_q;
  // The ALU doubles as the accumulator adder: b is the running sum during VRSUM.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) red_q <= '0;
    else if (accept && op_e'(op) == OP_RSUM) red_q <= '0;
    else if (rd && rsum) red_q <= alu_y;
`else
  assign rsum       = 1'b0;
  assign alu_b      = scalar_q;
  assign red_result = '0;
`endif
  vec_elem_alu #(.DW(DW)) u_alu (
    .op (op_q),
    .a  (elem),
    .b  (alu_b),
    .y  (alu_y)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = start ? ST_READ : ST_IDLE;
      ST_READ:  state_d = !last ? ST_READ : rsum ? ST_DONE : ST_WRITE;
      ST_WRITE: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end
  always_comb begin
    buf_d = buf_q;
    if (rd && !rsum) buf_d[idx_q*DW +: DW] = alu_y;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_ADDS;
      vs_q     <= '0;
      vd_q     <= '0;
      scalar_q <= '0;
      idx_q    <= '0;
      buf_q    <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      if (accept) begin
        op_q     <= op_e'(op);
        vs_q     <= vs;
        vd_q     <= vd;
        scalar_q <= scalar;
        idx_q    <= '0;
      end else if (rd) begin
        idx_q <= last ? '0 : idx_q + IW'(1);
      end
    end
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign rf_we    = (state_q == ST_WRITE);
  assign rf_vd    = vd_q;
  assign rf_wdata = buf_q;
  assign rf_va    = busy ? vs_q : vs;
endmodule

// File: tb/tb_vec_seq_ctrl.sv
// tb_vec_seq_ctrl: directed vector table, abort/ignore sequences and random ops
// checked against a behavioural register-file model.
module tb_vec_seq_ctrl;
  localparam int DW = 32, VLEN = 5, NVREG = 4, VW = DW * VLEN;
`ifdef VSEQ_REDUCE_EN
  localparam bit RED = 1'b1;
`else
  localparam bit RED = 1'b0;
`endif
  logic          clk = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic [1:0]    op = '0, vs = '0, vd = '0;
  logic [DW-1:0] scalar = '0, red_result;
  logic [VW-1:0] rf_rdata, rf_wdata;
  logic [1:0]    rf_va, rf_vd;
  logic          rf_we, busy, done;
  logic [VW-1:0] rf [NVREG];
  logic [VW-1:0] mrf [NVREG];
  logic          ld = 1'b0;
  logic [1:0]    ld_idx = '0;
  logic [VW-1:0] ld_val = '0;
  logic [DW-1:0] red_exp = '0;
  int n_chk = 0, n_fail = 0;

  vec_seq_ctrl #(.DW(DW), .VLEN(VLEN), .NVREG(NVREG)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .vs(vs), .vd(vd),
    .scalar(scalar), .rf_rdata(rf_rdata), .rf_va(rf_va), .rf_we(rf_we),
    .rf_vd(rf_vd), .rf_wdata(rf_wdata), .busy(busy), .done(done),
    .red_result(red_result)
  );

  always #5 clk = ~clk;
  assign rf_rdata = rf[rf_va];
  always @(posedge clk)
    if (rf_we) rf[rf_vd] <= rf_wdata;
    else if (ld) rf[ld_idx] <= ld_val;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [1:0]    op;
    logic [1:0]    vs, vd;
    logic [DW-1:0] sc;
    logic [VW-1:0] init;
    logic [VW-1:0] exp;
    string         nm;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [VW-1:0] mk5(input logic [DW-1:0] a, b, c, d, e);
    return {e, d, c, b, a};
  endfunction

  function automatic logic [VW-1:0] ref_op(input logic [1:0] o, input logic [VW-1:0] src, input logic [DW-1:0] sc);
    logic [VW-1:0] r;
    logic [DW-1:0] a;
    for (int i = 0; i < VLEN; i++) begin
      a = src[i*DW +: DW];
      case (o)
        2'd0: r[i*DW +: DW] = a + sc;
        2'd1: r[i*DW +: DW] = a - sc;
        2'd2: r[i*DW +: DW] = a & sc;
        default: r[i*DW +: DW] = a | sc;
      endcase
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] ref_sum(input logic [VW-1:0] src);
    logic [DW-1:0] s = '0;
    for (int i = 0; i < VLEN; i++) s += src[i*DW +: DW];
    return s;
  endfunction

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic load(input logic [1:0] idx, input logic [VW-1:0] val);
    @(negedge clk);
    ld = 1'b1; ld_idx = idx; ld_val = val;
    @(negedge clk);
    ld = 1'b0;
    mrf[idx] = val;
  endtask

  // Start one op and watch 16 cycles; xs1/xs2 are extra start pulses (cycle offsets, 0 = none).
  task automatic run_op(input logic [1:0] o, input logic [1:0] s, input logic [1:0] d,
                        input logic [DW-1:0] sc, input int xs1, input int xs2,
                        input logic [VW-1:0] exp_w, input bit rs, input logic [DW-1:0] exp_red,
                        input string nm);
    int we_cnt = 0, we_at = 0, done_cnt = 0, done_at = 0;
    logic [VW-1:0] wdata = '0;
    logic [1:0] wvd = '0;
    @(negedge clk);
    start = 1'b1; op = o; vs = s; vd = d; scalar = sc;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (rf_we) begin we_cnt++; we_at = k; wdata = rf_wdata; wvd = rf_vd; end
      if (done) begin done_cnt++; done_at = k; end
      if (k == 2) chk({nm, " rf_va"}, VW'(rf_va), VW'(s));
      if (k == 2) chk({nm, " busy"}, VW'(busy), VW'(1));
      start = (k == xs1) || (k == xs2);
      vs = ~s; vd = ~d; op = ~o; scalar = ~sc;
    end
    chk({nm, " we_cnt"}, VW'(we_cnt), rs ? VW'(0) : VW'(1));
    chk({nm, " done_cnt"}, VW'(done_cnt), VW'(1));
    chk({nm, " done_at"}, VW'(done_at), rs ? VW'(VLEN + 1) : VW'(VLEN + 2));
    chk({nm, " busy_end"}, VW'(busy), VW'(0));
    if (!rs) begin
      chk({nm, " we_at"}, VW'(we_at), VW'(VLEN + 1));
      chk({nm, " rf_vd"}, VW'(wvd), VW'(d));
      chk({nm, " wdata"}, wdata, exp_w);
      mrf[d] = exp_w;
    end else begin
      red_exp = exp_red;
    end
    chk({nm, " rf_dest"}, rf[d], mrf[d]);
    chk({nm, " red_result"}, VW'(red_result), VW'(red_exp));
  endtask

  initial begin
    logic [1:0] s, d, o;
    logic [DW-1:0] sc;
    bit we_seen;
    bit rs;
    vs = 2'd2;
    repeat (2) @(negedge clk);
    chk("rst busy", VW'(busy), VW'(0));
    chk("rst done", VW'(done), VW'(0));
    chk("rst rf_we", VW'(rf_we), VW'(0));
    chk("rst red_result", VW'(red_result), VW'(0));
    chk("rst rf_wdata", rf_wdata, '0);
    chk("idle rf_va", VW'(rf_va), VW'(2));
    reset_n = 1'b1;
    for (int i = 0; i < NVREG; i++) load(2'(i), '0);

    tbl.push_back('{2'd0, 2'd1, 2'd2, 32'd10, mk5(1, 2, 3, 4, 5), mk5(11, 12, 13, 14, 15), "vadds"});
    tbl.push_back('{2'd1, 2'd0, 2'd0, 32'd1, '0, {VLEN{32'hFFFF_FFFF}}, "vsubs_wrap"});
    tbl.push_back('{2'd2, 2'd3, 2'd1, 32'h0F0F_0F0F, {VLEN{32'hFFFF_00FF}}, {VLEN{32'h0F0F_000F}}, "vands"});
`ifndef VSEQ_REDUCE_EN
    tbl.push_back('{2'd3, 2'd2, 2'd3, 32'hF0, mk5(1, 2, 3, 4, 5), mk5(32'hF1, 32'hF2, 32'hF3, 32'hF4, 32'hF5), "vorrs"});
`endif
    foreach (tbl[i]) begin
      load(tbl[i].vs, tbl[i].init);
      run_op(tbl[i].op, tbl[i].vs, tbl[i].vd, tbl[i].sc, (i == 0) ? 3 : 0, (i == 0) ? 7 : 0,
             tbl[i].exp, 1'b0, '0, tbl[i].nm);
    end

`ifdef VSEQ_REDUCE_EN
    load(2'd1, mk5(1, 2, 3, 4, 5));
    run_op(2'd3, 2'd1, 2'd2, 32'hDEAD_BEEF, 0, 0, '0, 1'b1, 32'd15, "vrsum");
    run_op(2'd0, 2'd1, 2'd3, 32'd1, 0, 0, mk5(2, 3, 4, 5, 6), 1'b0, '0, "vadds_after_rsum");
`endif

    // Abort in the third READ cycle: nothing may be written.
    load(2'd1, {VLEN{32'd7}});
    load(2'd0, {VLEN{32'd9}});
    @(negedge clk);
    start = 1'b1; op = 2'd0; vs = 2'd1; vd = 2'd0; scalar = 32'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort busy", VW'(busy), VW'(0));
    chk("abort rf_we", VW'(rf_we), VW'(0));
    chk("abort done", VW'(done), VW'(0));
    chk("abort red_result", VW'(red_result), VW'(0));
    chk("abort rf_wdata", rf_wdata, '0);
    red_exp = '0;
    we_seen = 1'b0;
    repeat (3) begin @(negedge clk); we_seen |= rf_we; end
    reset_n = 1'b1;
    repeat (10) begin @(negedge clk); we_seen |= rf_we; end
    chk("abort no_write", VW'(we_seen), VW'(0));
    chk("abort dest_kept", rf[0], mrf[0]);
    run_op(2'd0, 2'd1, 2'd0, 32'd1, 0, 0, {VLEN{32'd8}}, 1'b0, '0, "after_abort");

    for (int it = 0; it < 24; it++) begin
      s = 2'($urandom_range(0, 3));
      d = 2'($urandom_range(0, 3));
      o = 2'($urandom_range(0, 3));
      sc = $urandom;
      if (it % 3 == 0) load(s, {$urandom, $urandom, $urandom, $urandom, $urandom});
      rs = RED && (o == 2'd3);
      run_op(o, s, d, sc, (it % 4 == 1) ? 2 : 0, (it % 4 == 1) ? 6 : 0,
             ref_op(o, mrf[s], sc), rs, ref_sum(mrf[s]), "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
